// File: rtl/swb_input_conditioner_pkg.sv
// Shared constants for the switch/button input conditioner: register map,
// default debounce timing and the counter-width helper.
package swb_pkg;

   localparam logic [1:0] SWB_ADDR_LEVEL = 2'd0;
   localparam logic [1:0] SWB_ADDR_RISE  = 2'd1;
   localparam logic [1:0] SWB_ADDR_FALL  = 2'd2;
   localparam logic [1:0] SWB_ADDR_MASK  = 2'd3;

   localparam int SWB_TICK_CYCLES_DEF = 100000;
   localparam int SWB_SAMPLES_DEF     = 3;

   // Bits needed to hold 0..v-1; never less than 1 so counters stay legal.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((longint'(1) << r) < longint'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/swb_input_conditioner_if.sv
// CPU-side register bus of the input conditioner: strobes, address, data.
interface swb_input_conditioner_if;
   logic        rd_en;
   logic        wr_en;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid;

   modport master (output rd_en, wr_en, addr, wr_data, input rd_data, rd_valid);
   modport slave  (input rd_en, wr_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/swb_input_conditioner_debounce.sv
// One input bit: 2-FF synchroniser, tick-sampled debounce counter, stable
// level and single-cycle rise/fall pulses aligned with the level update.
module swb_debounce_cell #(
   parameter int SAMPLES = 3,
   parameter int CW      = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   input  logic tick_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic [1:0]    sync_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (tick_i) begin
         if (sync_q[1] == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == CW'(SAMPLES - 1)) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign level_o = stable_q;
   assign rise_o  = ~stable_q &  stable_d;
   assign fall_o  =  stable_q & ~stable_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], raw_i};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/swb_input_conditioner.sv
// Switch/button input conditioner: debounced levels plus sticky RISE/FALL
// edge registers. Define SWB_IRQ_EN to enable the MASK register and irq.
module swb_input_conditioner
   import swb_pkg::*;
#(
   parameter int N_IN        = 19,
   parameter int TICK_CYCLES = SWB_TICK_CYCLES_DEF,
   parameter int SAMPLES     = SWB_SAMPLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_IN-1:0]        raw_in,
   swb_input_conditioner_if.slave bus,
   output logic [N_IN-1:0]        level,
   output logic                   irq
);
   localparam int TW = clog2(TICK_CYCLES);
   localparam int CW = clog2(SAMPLES);

   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            tick;
   logic [N_IN-1:0] rise_pls, fall_pls;
   logic [N_IN-1:0] rise_q, rise_d, fall_q, fall_d, mask_q, mask_d;
   logic [N_IN-1:0] wdat;
   logic [31:0]     rd_data_q, rd_data_d;
   logic            rd_valid_q, irq_q, irq_d;

   always_comb begin
      tick       = (tick_cnt_q == TW'(TICK_CYCLES - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   for (genvar g = 0; g < N_IN; g++) begin : g_cell
      swb_debounce_cell #(.SAMPLES(SAMPLES), .CW(CW)) u_cell (
         .clk    (clk),
         .rst    (rst),
         .raw_i  (raw_in[g]),
         .tick_i (tick),
         .level_o(level[g]),
         .rise_o (rise_pls[g]),
         .fall_o (fall_pls[g])
      );
   end

   // A hardware edge OR-ed in after the W1C mask, so a same-cycle set survives.
   always_comb begin
      wdat   = bus.wr_data[N_IN-1:0];
      rise_d = (rise_q & ~((bus.wr_en && bus.addr == SWB_ADDR_RISE) ? wdat : '0)) | rise_pls;
      fall_d = (fall_q & ~((bus.wr_en && bus.addr == SWB_ADDR_FALL) ? wdat : '0)) | fall_pls;
`ifdef SWB_IRQ_EN
      mask_d = (bus.wr_en && bus.addr == SWB_ADDR_MASK) ? wdat : mask_q;
      irq_d  = |((rise_q | fall_q) & mask_q);
`else
      mask_d = '0;
      irq_d  = 1'b0;
`endif
      rd_data_d = rd_data_q;
      if (bus.rd_en) begin
         case (bus.addr)
            SWB_ADDR_LEVEL: rd_data_d = 32'(level);
            SWB_ADDR_RISE:  rd_data_d = 32'(rise_q);
            SWB_ADDR_FALL:  rd_data_d = 32'(fall_q);
            default:        rd_data_d = 32'(mask_q);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_q <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
         mask_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         mask_q     <= mask_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= bus.rd_en;
         irq_q      <= irq_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign irq          = irq_q;
endmodule

// File: tb/tb_swb_input_conditioner.sv
// Bench for swb_input_conditioner: directed scenarios plus random traffic,
// all checked every cycle against a tick-sample history model.
module tb_swb_input_conditioner;
   import swb_pkg::*;

   localparam int N  = 19;
   localparam int TK = 4;
   localparam int SM = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  raw_in, level;
   logic          irq;
   logic [31:0]   d;
   int            lat, f;

   swb_input_conditioner_if bus ();

   swb_input_conditioner #(.N_IN(N), .TICK_CYCLES(TK), .SAMPLES(SM)) dut (
      .clk   (clk),
      .rst   (rst),
      .raw_in(raw_in),
      .bus   (bus),
      .level (level),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: level flips on a tick once the last SM tick samples of the
   // synchronised input all disagree with it and SM ticks have passed since
   // the previous flip.
   logic [N-1:0] m_rawq[$];
   logic [N-1:0] m_tq[$];
   int           m_since[N];
   logic [N-1:0] m_lvl, m_rise, m_fall, m_mask;
   logic [31:0]  m_rdd;
   logic         m_rdv, m_irq;
   int           m_cyc;

   task automatic model_edge(input logic r, input logic [N-1:0] rw, input logic re,
                             input logic we, input logic [1:0] a, input logic [31:0] wd);
      logic [N-1:0] sy, rs, fl, o_rise, o_fall, o_mask;
      bit tick, flip;
      if (!r) begin
         m_rawq.delete(); m_rawq.push_back('0); m_rawq.push_back('0);
         m_tq.delete();
         for (int i = 0; i < N; i++) m_since[i] = 0;
         m_lvl = '0; m_rise = '0; m_fall = '0; m_mask = '0;
         m_rdd = '0; m_rdv = 1'b0; m_irq = 1'b0; m_cyc = 0;
         return;
      end
      sy = m_rawq.pop_front();
      m_rawq.push_back(rw);
      o_rise = m_rise; o_fall = m_fall; o_mask = m_mask;
`ifdef SWB_IRQ_EN
      m_irq = |((o_rise | o_fall) & o_mask);
`else
      m_irq = 1'b0;
`endif
      m_rdv = re;
      if (re) begin
         case (a)
            SWB_ADDR_LEVEL: m_rdd = 32'(m_lvl);
            SWB_ADDR_RISE:  m_rdd = 32'(o_rise);
            SWB_ADDR_FALL:  m_rdd = 32'(o_fall);
            default:        m_rdd = 32'(o_mask);
         endcase
      end
      tick = (m_cyc % TK) == TK - 1;
      m_cyc++;
      rs = '0; fl = '0;
      if (tick) begin
         m_tq.push_back(sy);
         if (m_tq.size() > SM) void'(m_tq.pop_front());
         for (int i = 0; i < N; i++) begin
            m_since[i]++;
            flip = m_since[i] >= SM;
            foreach (m_tq[k]) if (m_tq[k][i] == m_lvl[i]) flip = 1'b0;
            if (flip) begin
               m_since[i] = 0;
               if (m_lvl[i]) fl[i] = 1'b1; else rs[i] = 1'b1;
            end
         end
         m_lvl = m_lvl ^ (rs | fl);
      end
      m_rise = (o_rise & ~((we && a == SWB_ADDR_RISE) ? wd[N-1:0] : '0)) | rs;
      m_fall = (o_fall & ~((we && a == SWB_ADDR_FALL) ? wd[N-1:0] : '0)) | fl;
`ifdef SWB_IRQ_EN
      if (we && a == SWB_ADDR_MASK) m_mask = wd[N-1:0];
`endif
   endtask

   task automatic cyc(input int n);
      logic r0, re0, we0;
      logic [N-1:0] rw0;
      logic [1:0] a0;
      logic [31:0] wd0;
      for (int k = 0; k < n; k++) begin
         r0 = rst; rw0 = raw_in; re0 = bus.rd_en; we0 = bus.wr_en;
         a0 = bus.addr; wd0 = bus.wr_data;
         @(posedge clk);
         model_edge(r0, rw0, re0, we0, a0, wd0);
         @(negedge clk);
         chk("level", 32'(level), 32'(m_lvl));
         chk("irq", 32'(irq), 32'(m_irq));
         chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
         chk("rd_data", bus.rd_data, m_rdd);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
      bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = wd;
      cyc(1);
      bus.wr_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] rd);
      bus.rd_en = 1'b1; bus.addr = a;
      cyc(1);
      bus.rd_en = 1'b0;
      rd = bus.rd_data;
   endtask

   task automatic wait_lvl(input int b, input logic v, input int lim, output int l);
      l = 0;
      while (level[b] !== v && l < lim) begin cyc(1); l++; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; raw_in = '1;
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
      #2 rst = 1'b0;

      // Reset with all inputs high, then accept them as rising edges.
      cyc(30);
      chk("rst_level", 32'(level), 32'h0);
      rst = 1'b1;
      lat = 0;
      while (level !== '1 && lat < 40) begin cyc(1); lat++; end
      chk("rst_lat_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
      bus_rd(SWB_ADDR_RISE, d);
      chk("rst_rise", d, 32'h7FFFF);
      raw_in = '0;
      cyc(24);
      bus_wr(SWB_ADDR_RISE, 32'hFFFF_FFFF);
      bus_wr(SWB_ADDR_FALL, 32'hFFFF_FFFF);
      bus_rd(SWB_ADDR_FALL, d);
      chk("clr_fall", d, 32'h0);

      // Short glitch is rejected.
      raw_in[1] = 1'b1; cyc(3); raw_in[1] = 1'b0; cyc(20);
      chk("glitch_lvl", 32'(level[1]), 32'h0);
      bus_rd(SWB_ADDR_RISE, d);
      chk("glitch_rise", d, 32'h0);

      // Press and release.
      raw_in[2] = 1'b1;
      wait_lvl(2, 1'b1, 15, lat);
      chk("press_lvl", 32'(level[2]), 32'h1);
      cyc(40 - lat - 1);
      bus_rd(SWB_ADDR_RISE, d);
      chk("press_rise", d, 32'h4);
      raw_in[2] = 1'b0;
      wait_lvl(2, 1'b0, 15, lat);
      chk("release_lvl", 32'(level[2]), 32'h0);
      bus_rd(SWB_ADDR_FALL, d);
      chk("release_fall", d, 32'h4);
      bus_wr(SWB_ADDR_RISE, 32'h4);
      bus_wr(SWB_ADDR_FALL, 32'h4);
      cyc(16);

      // W1C landing on the same edge as a new rising edge.
      f = 3;
      while (((m_cyc + f - 1) % TK) != TK - 1) f++;
      f = f + (SM - 1) * TK;
      raw_in[2] = 1'b1;
      cyc(f - 1);
      chk("race_pre", 32'(level[2]), 32'h0);
      bus_wr(SWB_ADDR_RISE, 32'h4);
      chk("race_lvl", 32'(level[2]), 32'h1);
      bus_rd(SWB_ADDR_RISE, d);
      chk("race_rise", d, 32'h4);
      bus_wr(SWB_ADDR_RISE, 32'h4);
      bus_rd(SWB_ADDR_RISE, d);
      chk("race_clr", d, 32'h0);
      raw_in[2] = 1'b0;
      cyc(16);
      bus_wr(SWB_ADDR_FALL, 32'h4);

`ifdef SWB_IRQ_EN
      bus_wr(SWB_ADDR_MASK, 32'h1);
      raw_in[0] = 1'b1;
      wait_lvl(0, 1'b1, 15, lat);
      chk("irq_pre", 32'(irq), 32'h0);
      cyc(1);
      chk("irq_set", 32'(irq), 32'h1);
      bus_wr(SWB_ADDR_RISE, 32'h1);
      chk("irq_hold", 32'(irq), 32'h1);
      cyc(1);
      chk("irq_clr", 32'(irq), 32'h0);
      raw_in[5] = 1'b1;
      cyc(20);
      chk("irq_unmasked", 32'(irq), 32'h0);
      bus_rd(SWB_ADDR_RISE, d);
      chk("rise_bit5", d, 32'h20);
`else
      bus_wr(SWB_ADDR_MASK, 32'h1);
      bus_rd(SWB_ADDR_MASK, d);
      chk("mask_off", d, 32'h0);
      raw_in[0] = 1'b1; raw_in[5] = 1'b1;
      cyc(20);
      chk("irq_off", 32'(irq), 32'h0);
`endif

      // Read timing on LEVEL.
      raw_in = 19'h00042;
      cyc(20);
      bus.rd_en = 1'b1; bus.addr = SWB_ADDR_LEVEL;
      cyc(1);
      bus.rd_en = 1'b0;
      chk("rd_timing_valid", 32'(bus.rd_valid), 32'h1);
      chk("rd_timing_data", bus.rd_data, 32'h00000042);
      cyc(1);
      chk("rd_timing_idle", 32'(bus.rd_valid), 32'h0);

      // Random traffic including a noisy bit and a mid-debounce reset.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0) raw_in[$urandom_range(0, N - 2)] ^= 1'b1;
         if ($urandom_range(0, 3) == 0) raw_in[N-1] ^= 1'b1;
         bus.rd_en   = ($urandom_range(0, 2) == 0);
         bus.wr_en   = ($urandom_range(0, 3) == 0);
         bus.addr    = 2'($urandom_range(0, 3));
         bus.wr_data = $urandom;
         rst = !(k >= 700 && k < 703);
         cyc(1);
      end
      bus.rd_en = 1'b0; bus.wr_en = 1'b0; rst = 1'b1;
      cyc(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
